// File: rtl/lift_pkg.sv
// Shared definitions for the lift request queue: call codes, button
// indices and the code/index conversion helpers.
package lift_pkg;

    // Number of hall-call buttons (and pending lamp bits).
    localparam int NCALL = 6;

    // Encoded call codes presented to the lift controller.
    localparam logic [2:0] CALL_NONE = 3'b000;
    localparam logic [2:0] CALL_1U   = 3'b001;
    localparam logic [2:0] CALL_2U   = 3'b010;
    localparam logic [2:0] CALL_3U   = 3'b011;
    localparam logic [2:0] CALL_2D   = 3'b110;
    localparam logic [2:0] CALL_3D   = 3'b111;
    localparam logic [2:0] CALL_4D   = 3'b100;

    // Bit positions of each call within btn / req / inq / pending.
    localparam int BTN_1U = 0;
    localparam int BTN_2U = 1;
    localparam int BTN_3U = 2;
    localparam int BTN_2D = 3;
    localparam int BTN_3D = 4;
    localparam int BTN_4D = 5;

    // Button index -> call code. Out-of-range indices map to CALL_NONE.
    function automatic logic [2:0] idx2code(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = CALL_1U;
            3'd1:    code = CALL_2U;
            3'd2:    code = CALL_3U;
            3'd3:    code = CALL_2D;
            3'd4:    code = CALL_3D;
            3'd5:    code = CALL_4D;
            default: code = CALL_NONE;
        endcase
        return code;
    endfunction

    // Call code -> button index. CALL_NONE (and the unused code 101)
    // map to index 0; callers only use this on a valid head entry.
    function automatic logic [2:0] code2idx(input logic [2:0] code);
        logic [2:0] idx;
        case (code)
            CALL_1U: idx = 3'd0;
            CALL_2U: idx = 3'd1;
            CALL_3U: idx = 3'd2;
            CALL_2D: idx = 3'd3;
            CALL_3D: idx = 3'd4;
            CALL_4D: idx = 3'd5;
            default: idx = 3'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/lift_req_fifo.sv
// Plain synchronous FIFO holding 3-bit call codes. A push while full is
// accepted only when a pop happens on the same edge (the slot being
// freed is the one being written). Read data is the head entry, taken
// straight from registered storage.
module lift_req_fifo #(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [2:0] wdata,
    input  logic       pop,
    output logic [2:0] rdata,
    output logic       empty,
    output logic       full
);

    logic [2:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;

    logic w_wr;
    logic w_rd;

    assign empty = (r_count == '0);
    assign full  = (r_count == (PW+1)'(DEPTH));
    assign rdata = r_mem[r_rptr];

    // Qualified write/read strobes; pop on empty is ignored.
    assign w_rd = pop & ~empty;
    assign w_wr = push & (~full | w_rd);

    // Storage, pointers (wrap naturally, DEPTH is a power of 2) and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 3'b000;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lift_req_queue.sv
// Lift request queue: latches hall-call presses, de-duplicates them
// against waiting (req) and queued (inq) calls, pushes one call per
// cycle in fixed priority (lowest button index first) into a FIFO, and
// presents the head call to the lift controller.
//
// Handshake with the lift controller: din/q_empty are driven from
// registered state only. The controller raises done when it can take a
// call; an entry is consumed on a rising edge where done=1 and
// q_empty=0. done while q_empty=1 has no effect.
//
// Optional build macro LIFT_REQ_STATS_EN adds stat_dup, a saturating
// count of coalesced (dropped duplicate) button presses.
import lift_pkg::*;

module lift_req_queue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] btn,
    input  logic       done,
    output logic [2:0] din,
    output logic       q_empty,
    output logic       full,
    output logic [5:0] pending
`ifdef LIFT_REQ_STATS_EN
    ,
    output logic [7:0] stat_dup
`endif
);

    logic [5:0] r_req;
    logic [5:0] r_inq;

    logic [2:0] w_head;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic [5:0] w_popbit;
    logic [5:0] w_new;
    logic [2:0] w_sel;
    logic [5:0] w_selbit;
    logic       w_push;
    logic [2:0] w_push_code;

    lift_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (w_push_code),
        .pop   (w_pop),
        .rdata (w_head),
        .empty (w_empty),
        .full  (w_full)
    );

    // The head call's lamp bit clears on the edge it is consumed.
    assign w_pop    = done & ~w_empty;
    assign w_popbit = w_pop ? (6'(1) << code2idx(w_head)) : 6'b000000;

    // Presses already waiting or queued (and not leaving this edge) are
    // coalesced; a press of the call being popped counts as a new call.
    assign w_new = btn & ~r_req & ~(r_inq & ~w_popbit);

    // Priority select: lowest set bit of the registered waiting set.
    always_comb begin
        w_sel = 3'd0;
        for (int i = NCALL - 1; i >= 0; i--) begin
            if (r_req[i]) begin
                w_sel = 3'(i);
            end
        end
    end

    // A slot is available if the FIFO has room or one is freed this edge.
    assign w_push      = (|r_req) & (~w_full | w_pop);
    assign w_selbit    = w_push ? (6'(1) << w_sel) : 6'b000000;
    assign w_push_code = idx2code(w_sel);

    // Waiting/queued bookkeeping; req and inq stay disjoint.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req <= 6'b000000;
            r_inq <= 6'b000000;
        end else begin
            r_req <= (r_req | w_new) & ~w_selbit;
            r_inq <= (r_inq & ~w_popbit) | w_selbit;
        end
    end

    assign din     = w_empty ? CALL_NONE : w_head;
    assign q_empty = w_empty;
    assign full    = w_full;
    assign pending = r_req | r_inq;

`ifdef LIFT_REQ_STATS_EN
    logic [7:0] r_stat;
    logic [5:0] w_dup;
    logic [2:0] w_dup_cnt;
    logic [8:0] w_stat_sum;

    assign w_dup = btn & ~w_new;

    // Number of coalesced button bits this cycle (0..6).
    always_comb begin
        w_dup_cnt = 3'd0;
        for (int i = 0; i < NCALL; i++) begin
            w_dup_cnt = w_dup_cnt + 3'(w_dup[i]);
        end
    end

    assign w_stat_sum = {1'b0, r_stat} + 9'(w_dup_cnt);

    // Saturating duplicate-press counter, holds at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat <= 8'd0;
        end else if (w_stat_sum[8]) begin
            r_stat <= 8'hFF;
        end else begin
            r_stat <= w_stat_sum[7:0];
        end
    end

    assign stat_dup = r_stat;
`endif

endmodule

// File: tb/tb_lift_req_queue.sv
// Directed bench for lift_req_queue. Expected call codes are queued as
// presses are issued; a monitor consumes them on every accepted pop.
module tb_lift_req_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] btn;
    logic       done;
    logic [2:0] din;
    logic       q_empty;
    logic       full;
    logic [5:0] pending;
`ifdef LIFT_REQ_STATS_EN
    logic [7:0] stat_dup;
`endif

    int tests = 0;
    int fails = 0;
    logic [2:0] exp_q[$];

    lift_req_queue #(.DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .done    (done),
        .din     (din),
        .q_empty (q_empty),
        .full    (full),
        .pending (pending)
`ifdef LIFT_REQ_STATS_EN
        ,
        .stat_dup (stat_dup)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a pop happens on the next edge, check the head.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1 && q_empty === 1'b0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got %0h expected none", din);
            end else begin
                check("pop_order", {5'b0, din}, {5'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst  = 1'b1;
        btn  = 6'b000000;
        done = 1'b0;
        tick();
        tick();
        // Outputs while held in reset
        check("rst_q_empty", {7'b0, q_empty}, 8'h01);
        check("rst_full", {7'b0, full}, 8'h00);
        check("rst_din", {5'b0, din}, 8'h00);
        check("rst_pending", {2'b0, pending}, 8'h00);
        rst = 1'b0;

        // 1: idle with done=1
        done = 1'b1;
        repeat (5) tick();
        done = 1'b0;
        check("idle_q_empty", {7'b0, q_empty}, 8'h01);
        check("idle_din", {5'b0, din}, 8'h00);
        check("idle_pending", {2'b0, pending}, 8'h00);
`ifdef LIFT_REQ_STATS_EN
        check("stat_reset", stat_dup, 8'h00);
`endif

        // 2: single 2U press, latency
        btn = 6'b000010;
        tick();
        btn = 6'b000000;
        exp_q.push_back(3'b010);
        check("s2_pending_req", {2'b0, pending}, 8'h02);
        check("s2_q_empty_early", {7'b0, q_empty}, 8'h01);
        tick();
        check("s2_din", {5'b0, din}, 8'h02);
        check("s2_q_empty", {7'b0, q_empty}, 8'h00);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("s2_pending_clr", {2'b0, pending}, 8'h00);
        check("s2_empty_after", {7'b0, q_empty}, 8'h01);

        // 3: simultaneous 1U,3U,4D -> priority order
        btn = 6'b100101;
        tick();
        btn = 6'b000000;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b100);
        repeat (3) tick();
        check("s3_pending", {2'b0, pending}, 8'h25);
        done = 1'b1;
        tick();
        check("s3_pending_pop1", {2'b0, pending}, 8'h24);
        tick();
        check("s3_pending_pop2", {2'b0, pending}, 8'h20);
        tick();
        done = 1'b0;
        check("s3_pending_pop3", {2'b0, pending}, 8'h00);
        check("s3_empty", {7'b0, q_empty}, 8'h01);

        // 4: repeated 2U presses coalesce into one entry
        exp_q.push_back(3'b010);
        btn = 6'b000010;
        repeat (3) tick();
        btn = 6'b000000;
        tick();
        check("s4_pending", {2'b0, pending}, 8'h02);
`ifdef LIFT_REQ_STATS_EN
        check("s4_stat_dup", stat_dup, 8'h02);
`endif
        done = 1'b1;
        tick();
        check("s4_single_entry", {7'b0, q_empty}, 8'h01);
        tick();
        done = 1'b0;
        check("s4_pending_clr", {2'b0, pending}, 8'h00);

        // 5: all six buttons, FIFO fills, req holds the rest
        btn = 6'b111111;
        tick();
        btn = 6'b000000;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b110);
        exp_q.push_back(3'b111);
        exp_q.push_back(3'b100);
        repeat (4) tick();
        check("s5_full", {7'b0, full}, 8'h01);
        check("s5_pending", {2'b0, pending}, 8'h3f);
        check("s5_head", {5'b0, din}, 8'h01);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("s5_full_after_pop", {7'b0, full}, 8'h01);
        check("s5_head2", {5'b0, din}, 8'h02);
        check("s5_pending_pop", {2'b0, pending}, 8'h3e);
        tick();
        check("s5_full_hold", {7'b0, full}, 8'h01);
        done = 1'b1;
        repeat (6) tick();
        done = 1'b0;
        check("s5_drained", {7'b0, q_empty}, 8'h01);
        check("s5_not_full", {7'b0, full}, 8'h00);
        check("s5_pending_clr", {2'b0, pending}, 8'h00);

        // 6: reset mid-drain discards everything
        btn = 6'b001111;
        tick();
        btn = 6'b000000;
        exp_q.push_back(3'b001);
        repeat (4) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("s6_pending_pre", {2'b0, pending}, 8'h0e);
        rst = 1'b1;
        #1;
        check("s6_rst_q_empty", {7'b0, q_empty}, 8'h01);
        check("s6_rst_din", {5'b0, din}, 8'h00);
        check("s6_rst_pending", {2'b0, pending}, 8'h00);
        check("s6_rst_full", {7'b0, full}, 8'h00);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        btn = 6'b000010;
        tick();
        btn = 6'b000000;
        exp_q.push_back(3'b010);
        check("s6_pending_req", {2'b0, pending}, 8'h02);
        check("s6_q_empty_early", {7'b0, q_empty}, 8'h01);
        tick();
        check("s6_din", {5'b0, din}, 8'h02);
        check("s6_q_empty", {7'b0, q_empty}, 8'h00);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check("s6_final_empty", {7'b0, q_empty}, 8'h01);

        check("scoreboard_drained", 8'(exp_q.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
